// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and sequencer error codes.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

endpackage

// File: rtl/pll_ahb_cfg_sequencer.sv
// AHB-Lite manager: writes the PLL config registers, then polls status until lock or timeout.
module pll_ahb_cfg_sequencer
    import ahb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_WRITES  = 4,
    parameter logic [ADDR_WIDTH-1:0] CFG_BASE    = '0,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(32'h0000_0040),
    parameter logic [DATA_WIDTH-1:0] LOCK_MASK   = DATA_WIDTH'(32'h0000_0001),
    parameter int unsigned           POLL_LIMIT  = 1024,
    parameter int unsigned           POLL_GAP    = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             start,
    input  logic [NUM_WRITES*DATA_WIDTH-1:0] cfg_data,
    output logic                             busy,
    output logic                             done,
    output logic [1:0]                       err,
    output logic                             HSEL,
    output logic [1:0]                       HTRANS,
    output logic [ADDR_WIDTH-1:0]            HADDR,
    output logic                             HWRITE,
    output logic [2:0]                       HSIZE,
    output logic [2:0]                       HBURST,
    output logic                             HMASTLOCK,
    output logic [DATA_WIDTH-1:0]            HWDATA,
    output logic [DATA_WIDTH/8-1:0]          HWSTRB,
    input  logic                             HREADY,
    input  logic                             HRESP,
    input  logic [DATA_WIDTH-1:0]            HRDATA
);

    localparam int unsigned IDX_W  = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
    localparam int unsigned POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam int unsigned GAP_W  = (POLL_GAP > 1)   ? $clog2(POLL_GAP)   : 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_POLL_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [POLL_W-1:0]       poll_q, poll_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    done_q, done_d;
    err_code_t               err_q, err_d;
    logic                    busy_q, busy_d;
    htrans_t                 htrans_q, htrans_d;
    logic                    hsel_q, hsel_d;
    logic                    hwrite_q, hwrite_d;
    logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
    logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
    logic [STRB_W-1:0]       hwstrb_q, hwstrb_d;
    logic                    locked_c;

    assign locked_c = ((HRDATA & LOCK_MASK) == LOCK_MASK);

    // Next-state sequencing plus next values of the registered bus/status outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        done_d   = done_q;
        err_d    = err_q;
        htrans_d = IDLE;
        hsel_d   = 1'b0;
        hwrite_d = 1'b0;
        haddr_d  = '0;
        hwdata_d = '0;
        hwstrb_d = '0;
        busy_d   = 1'b1;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = ERR_NONE;
                    idx_d   = '0;
                    poll_d  = '0;
                    gap_d   = '0;
                    state_d = ST_WR_ADDR;
                end
            end
            ST_WR_ADDR: begin
                if (HREADY) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (HRESP) begin
                    err_d   = ERR_BUS;
                    state_d = ST_ERROR;
                end else if (HREADY) begin
                    if (idx_q == IDX_W'(NUM_WRITES - 1)) begin
                        state_d = ST_RD_ADDR;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_WR_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (HREADY) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (HRESP) begin
                    err_d   = ERR_BUS;
                    state_d = ST_ERROR;
                end else if (HREADY) begin
                    if (locked_c) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (poll_q == POLL_W'(POLL_LIMIT - 1)) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_ERROR;
                    end else begin
                        poll_d  = poll_q + POLL_W'(1);
                        gap_d   = '0;
                        state_d = (POLL_GAP == 0) ? ST_RD_ADDR : ST_POLL_WAIT;
                    end
                end
            end
            ST_POLL_WAIT: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = ST_RD_ADDR;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_WR_ADDR: begin
                htrans_d = NONSEQ;
                hsel_d   = 1'b1;
                hwrite_d = 1'b1;
                haddr_d  = CFG_BASE + (ADDR_WIDTH'(idx_d) << 2);
            end
            ST_WR_DATA: begin
                // Data is captured on entry to the data phase and held through wait states.
                hwdata_d = (state_q == ST_WR_DATA) ? hwdata_q
                                                   : cfg_data[32'(idx_d) * DATA_WIDTH +: DATA_WIDTH];
                hwstrb_d = '1;
            end
            ST_RD_ADDR: begin
                htrans_d = NONSEQ;
                hsel_d   = 1'b1;
                haddr_d  = STATUS_ADDR;
            end
            ST_IDLE, ST_DONE, ST_ERROR: busy_d = 1'b0;
            default: ;
        endcase
    end

    // State, counters and registered outputs; reset drops the bus to IDLE at once.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            poll_q   <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
            busy_q   <= 1'b0;
            htrans_q <= IDLE;
            hsel_q   <= 1'b0;
            hwrite_q <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hwstrb_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            htrans_q <= htrans_d;
            hsel_q   <= hsel_d;
            hwrite_q <= hwrite_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            hwstrb_q <= hwstrb_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign HSEL      = hsel_q;
    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HWSTRB    = hwstrb_q;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;

endmodule

// File: doc/pll_ahb_cfg_sequencer.md
Name: pll_ahb_cfg_sequencer

Overview:
- AHB-Lite manager that programs the PLL's AHB-mapped configuration registers, then polls the PLL status register until lock.
- Issues NUM_WRITES single-word writes to consecutive word addresses from CFG_BASE, then repeatedly reads STATUS_ADDR until all LOCK_MASK bits are set or the poll limit expires.
- Sits between the boot/control logic (start/done/err) and the manager side of the ahb_if bus.

Parameters:
- ADDR_WIDTH, 32, AHB address width
- DATA_WIDTH, 32, AHB data width; only 32 is supported (HSIZE fixed at word)
- NUM_WRITES, 4, number of configuration writes (1..16)
- CFG_BASE, 32'h0000_0000, address of the first config register; write i goes to CFG_BASE + 4*i
- STATUS_ADDR, 32'h0000_0040, address of the PLL status register
- LOCK_MASK, 32'h0000_0001, status bits that must all read 1 for lock
- POLL_LIMIT, 1024, maximum number of status reads before timeout (at least 1)
- POLL_GAP, 8, idle cycles between status reads (0 allowed)

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins the sequence
- cfg_data  in  NUM_WRITES*DATA_WIDTH  write data; slice i is for write i; sampled when that write's data phase begins
- busy  out  1  sequence in progress
- done  out  1  sticky; lock seen
- err  out  2  sticky; 0 none, 1 bus error (HRESP), 2 lock timeout
- HSEL  out  1  asserted with NONSEQ address phases
- HTRANS  out  2  IDLE or NONSEQ only
- HADDR  out  ADDR_WIDTH  transfer address
- HWRITE  out  1  1 for a write address phase
- HSIZE  out  3  fixed 3'b010
- HBURST  out  3  fixed 3'b000 (SINGLE)
- HMASTLOCK  out  1  fixed 0
- HWDATA  out  DATA_WIDTH  write data during the data phase
- HWSTRB  out  DATA_WIDTH/8  all ones during a write data phase, else 0
- HREADY  in  1  transfer complete
- HRESP  in  1  1 = ERROR
- HRDATA  in  DATA_WIDTH  read data

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is HCLK, reset port is HRESET.
- Reset values:
  - State IDLE.
  - HTRANS=IDLE, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, HWSTRB=0.
  - busy=0, done=0, err=0.
  - Write index and poll counters cleared.
- Transfers are strictly single and non-overlapped: one address phase, then its data phase, then the next address phase.
- States:
  - IDLE: on start, clear done/err, set idx=0, go to WR_ADDR.
  - WR_ADDR: drive NONSEQ, HSEL=1, HWRITE=1, HADDR=CFG_BASE+4*idx. Address phase completes when HREADY=1; then go to WR_DATA.
  - WR_DATA: HTRANS=IDLE, HSEL=0, HWDATA=cfg_data slice idx, HWSTRB all ones. Hold until HREADY=1.
    - HRESP=1 in any data-phase cycle: go to ERROR with err=1, abandoning the rest of the sequence.
    - Otherwise: if idx==NUM_WRITES-1 go to RD_ADDR, else idx+1 and go to WR_ADDR.
  - RD_ADDR: NONSEQ, HWRITE=0, HADDR=STATUS_ADDR; go to RD_DATA on HREADY.
  - RD_DATA: wait for HREADY. HRESP handling is the same as in WR_DATA.
    - (HRDATA & LOCK_MASK)==LOCK_MASK: go to DONE.
    - Else, if polls==POLL_LIMIT-1: go to ERROR with err=2.
    - Else polls+1; go to POLL_WAIT, or directly to RD_ADDR when POLL_GAP=0.
  - POLL_WAIT: count POLL_GAP cycles with HTRANS=IDLE, then go to RD_ADDR.
  - DONE: done=1, bus IDLE.
  - ERROR: err held, bus IDLE.
- busy=1 in every state except IDLE, DONE and ERROR.
- start in DONE or ERROR restarts the sequence, identical to start in IDLE.
- start while busy is ignored.
- Latency with zero-wait-state subordinate and POLL_GAP=0: each transfer takes 2 cycles. First-read lock gives done at 2*(NUM_WRITES+1)+1 cycles after start.
- Reset mid-transfer forces HTRANS=IDLE immediately (asynchronous); no transfer is resumed.

Decomposition:
- ahb_pkg holds:
  - htrans_t enum (IDLE=2'b00, BUSY, NONSEQ, SEQ)
  - HSIZE_WORD=3'b010, HBURST_SINGLE=3'b000
  - err_code_t enum (ERR_NONE, ERR_BUS, ERR_TIMEOUT)
- State enum is local to the module.
- No sub-module; the gap and poll counters are inline.

Test Plan:
- Zero-wait subordinate, NUM_WRITES=4, cfg_data={D3..D0}, status reads 0x1 on the first poll -> writes D0..D3 to 0x0,0x4,0x8,0xC in order, one read of 0x40, done=1 at cycle 11 after start, err=0.
- HREADY held low 3 cycles in write 2's data phase -> HWDATA, HWSTRB and state held stable; HADDR 0x8 is not reissued; sequence continues.
- HRESP=1 on write 1 -> err=1, done=0, no further NONSEQ issued, busy=0.
- Status 0x0 forever with POLL_LIMIT=4, POLL_GAP=2 -> exactly 4 reads with 2 idle cycles between each, then err=2.
- Status 0x0 for 3 reads then 0x1 -> done=1 after read 4. A start pulse during polling is ignored; a new start after done reruns the full sequence.
- HRESET asserted during RD_ADDR -> outputs return to reset values in the same cycle; after release the block stays IDLE until start.
